// File: rtl/funnel_wrr_sched.sv
// -----------------------------------------------------------------------------
// funnel_wrr_sched
//   Weighted round-robin scheduler that lets funnelWidth buffered requesters
//   share a single enqueue sink. One requester (the owner) is granted at a time.
//   It keeps the grant for a burst of up to weight[owner] transfers, and then
//   the grant rotates to the next eligible requester. Weights are written at
//   run time. A weight of 0 disables that requester.
//
// Ports
//   CLK, nRST                 clock; synchronous active-low reset
//   in_pending_i[i]           requester i holds data (level)
//   in_enq_ENA_i[i]           requester i transfers (legal only while RDY[i])
//   in_enq_v_i                payloads, requester i at [i*dataWidth +: dataWidth]
//   in_enq_RDY_o[i]           requester i may transfer this cycle
//   out_enq_ENA_o/_v_o        transfer strobe / payload towards the sink
//   out_enq_RDY_i             sink can accept
//   cfg_setWeight_*_i         weight write: enable, requester index, new weight
//   cfg_setWeight_RDY_o       always 1
// -----------------------------------------------------------------------------
module funnel_wrr_sched #(
    parameter int funnelWidth = 4,
    parameter int dataWidth   = 32,
    parameter int weightWidth = 4,
    localparam int idxWidth   = $clog2(funnelWidth)
) (
    input  logic                             CLK,
    input  logic                             nRST,
    input  logic [funnelWidth-1:0]           in_pending_i,
    input  logic [funnelWidth-1:0]           in_enq_ENA_i,
    input  logic [funnelWidth*dataWidth-1:0] in_enq_v_i,
    output logic [funnelWidth-1:0]           in_enq_RDY_o,
    output logic                             out_enq_ENA_o,
    output logic [dataWidth-1:0]             out_enq_v_o,
    input  logic                             out_enq_RDY_i,
    input  logic                             cfg_setWeight_ENA_i,
    input  logic [idxWidth-1:0]              cfg_setWeight_idx_i,
    input  logic [weightWidth-1:0]           cfg_setWeight_w_i,
    output logic                             cfg_setWeight_RDY_o
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 state_q, state_d;
    logic [idxWidth-1:0]    owner_q, owner_d;
    logic [idxWidth-1:0]    ptr_q, ptr_d;
    logic [weightWidth-1:0] count_q, count_d;
    logic [weightWidth-1:0] weight_q [funnelWidth];

    logic [funnelWidth-1:0] eligible;
    logic [idxWidth-1:0]    owner_nxt;
    logic                   xfer;
    logic [weightWidth:0]   count_inc;
    logic                   burst_end;

    // First eligible index scanning start, start+1, ... (mod funnelWidth).
    // The loop runs from the far end, so the closest hit is the last one written.
    function automatic logic [idxWidth-1:0] pick(input logic [funnelWidth-1:0] elig,
                                                 input logic [idxWidth-1:0]    start);
        logic [idxWidth-1:0] res;
        int j;
        res = start;
        for (int k = funnelWidth - 1; k >= 0; k--) begin
            j = (int'(start) + k) % funnelWidth;
            if (elig[j]) res = idxWidth'(j);
        end
        return res;
    endfunction

    always_comb begin
        eligible = '0;
        for (int i = 0; i < funnelWidth; i++) begin
            eligible[i] = in_pending_i[i] && (weight_q[i] != '0);
        end
    end

    assign owner_nxt = (int'(owner_q) == funnelWidth - 1) ? '0 : owner_q + 1'b1;

    // A transfer needs the owner's ENA and a ready sink. ENA without RDY is ignored.
    assign xfer      = (state_q == BURST) && in_enq_ENA_i[owner_q] && out_enq_RDY_i;
    assign count_inc = {1'b0, count_q} + 1'b1;

    // The live weight is used, so a weight lowered mid-burst ends the burst
    // on the next transfer. With no transfer, the burst ends only if the owner
    // has lost eligibility. A stalled sink alone never ends the burst.
    assign burst_end = xfer ? (count_inc >= {1'b0, weight_q[owner_q]})
                            : !eligible[owner_q];

    // State register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < funnelWidth; i++) begin
                weight_q[i] <= weightWidth'(1);
            end
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            // The burst compare this cycle still sees the old weight.
            if (cfg_setWeight_ENA_i && (int'(cfg_setWeight_idx_i) < funnelWidth)) begin
                weight_q[cfg_setWeight_idx_i] <= cfg_setWeight_w_i;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = BURST;
                    owner_d = pick(eligible, ptr_q);
                    count_d = '0;
                end
            end
            BURST: begin
                if (burst_end) begin
                    ptr_d = owner_nxt;
                    // The old owner is scanned last. It is re-chosen only if no other requester is eligible.
                    if (|eligible) begin
                        owner_d = pick(eligible, owner_nxt);
                        count_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    count_d = count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: a combinational pass-through from the owner to the sink.
    always_comb begin
        in_enq_RDY_o  = '0;
        out_enq_ENA_o = 1'b0;
        out_enq_v_o   = '0;
        if (state_q == BURST) begin
            in_enq_RDY_o[owner_q] = out_enq_RDY_i;
            out_enq_ENA_o         = xfer;
            out_enq_v_o           = in_enq_v_i[owner_q*dataWidth +: dataWidth];
        end
    end

    assign cfg_setWeight_RDY_o = 1'b1;

    // A requester must not strobe ENA while it is not granted.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            assert ((in_enq_ENA_i & ~in_enq_RDY_o) == '0);
        end
    end

endmodule

// File: tb/tb_funnel_wrr_sched.sv
// -----------------------------------------------------------------------------
// tb_funnel_wrr_sched
//   Self-checking bench for funnel_wrr_sched (4 requesters, 32-bit data,
//   4-bit weights). Directed vector tables and hand-written sequences cover
//   the multi-cycle corner cases. A randomized run is compared each cycle
//   against a behavioural scheduler model.
// -----------------------------------------------------------------------------
module tb_funnel_wrr_sched;

    logic         CLK;
    logic         nRST;
    logic [3:0]   pending;
    logic [3:0]   ena;
    logic [127:0] v;
    logic [3:0]   rdy;
    logic         oena;
    logic [31:0]  ov;
    logic         osrdy;
    logic         cen;
    logic [1:0]   cidx;
    logic [3:0]   cw;
    logic         crdy;

    int checks = 0;
    int errors = 0;

    funnel_wrr_sched #(.funnelWidth(4), .dataWidth(32), .weightWidth(4)) dut (
        .CLK                 (CLK),
        .nRST                (nRST),
        .in_pending_i        (pending),
        .in_enq_ENA_i        (ena),
        .in_enq_v_i          (v),
        .in_enq_RDY_o        (rdy),
        .out_enq_ENA_o       (oena),
        .out_enq_v_o         (ov),
        .out_enq_RDY_i       (osrdy),
        .cfg_setWeight_ENA_i (cen),
        .cfg_setWeight_idx_i (cidx),
        .cfg_setWeight_w_i   (cw),
        .cfg_setWeight_RDY_o (crdy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scheduler model: who owns the sink, how many transfers the owner has
    // made, where the next search starts, and the weight table.
    bit m_busy;
    int m_owner, m_ptr, m_cnt;
    int m_w [4];

    function automatic int mpick(input logic [3:0] el, input int start);
        for (int k = 0; k < 4; k++) begin
            if (el[(start + k) % 4]) return (start + k) % 4;
        end
        return start;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        for (int i = 0; i < 4; i++) m_w[i] = 1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one cycle at the falling edge and checks the combinational outputs.
    // Requesters strobe ENA only where the model grants them. The model then
    // advances by the rising edge that follows.
    task automatic step(input logic rstn, input logic [3:0] pend, input logic [3:0] want,
                        input logic srdy, input logic ce, input logic [1:0] ci,
                        input logic [3:0] cwv, output logic [3:0] rdy_seen);
        logic [3:0]  exp_rdy, en, el;
        logic [31:0] exp_v;
        bit          x, done;
        @(negedge CLK);
        exp_rdy = (m_busy && srdy) ? (4'b0001 << m_owner) : 4'b0000;
        en      = want & exp_rdy;
        nRST = rstn; pending = pend; ena = en; osrdy = srdy;
        cen = ce; cidx = ci; cw = cwv;
        for (int i = 0; i < 4; i++) v[i*32 +: 32] = $urandom;
        exp_v = m_busy ? v[m_owner*32 +: 32] : 32'h0;
        #1;
        check("in_rdy",  {28'h0, rdy}, {28'h0, exp_rdy});
        check("out_ena", {31'h0, oena}, {31'h0, |en});
        check("out_v",   ov, exp_v);
        rdy_seen = rdy;
        if (!rstn) begin
            model_reset();
        end else begin
            for (int i = 0; i < 4; i++) el[i] = pend[i] && (m_w[i] != 0);
            x = m_busy && en[m_owner];
            if (!m_busy) begin
                if (el != 0) begin
                    m_busy = 1; m_owner = mpick(el, m_ptr); m_cnt = 0;
                end
            end else begin
                done = x ? (m_cnt + 1 >= m_w[m_owner]) : !el[m_owner];
                if (done) begin
                    m_ptr = (m_owner + 1) % 4;
                    if (el != 0) begin
                        m_owner = mpick(el, m_ptr); m_cnt = 0;
                    end else begin
                        m_busy = 0;
                    end
                end else if (x) begin
                    m_cnt++;
                end
            end
            if (ce) m_w[ci] = cwv;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0; pending = '0; ena = '0; osrdy = 1'b1;
        cen = 1'b0; cidx = '0; cw = '0;
        repeat (2) @(posedge CLK);
        model_reset();
    endtask

    typedef struct {
        bit         rst_first;
        logic [3:0] pend;
        logic [3:0] want;
        logic       srdy;
        logic       ce;
        logic [1:0] ci;
        logic [3:0] cwv;
        logic [3:0] exp_rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit rf, input logic [3:0] p, input logic [3:0] w,
                                input logic s, input logic ce, input logic [1:0] ci,
                                input logic [3:0] cwv, input logic [3:0] er);
        vec_t r;
        r.rst_first = rf; r.pend = p; r.want = w; r.srdy = s;
        r.ce = ce; r.ci = ci; r.cwv = cwv; r.exp_rdy = er;
        tbl.push_back(r);
    endfunction

    task automatic expect_step(input string name, input logic rstn, input logic [3:0] pend,
                               input logic [3:0] want, input logic srdy, input logic ce,
                               input logic [1:0] ci, input logic [3:0] cwv,
                               input logic [3:0] er);
        logic [3:0] seen;
        step(rstn, pend, want, srdy, ce, ci, cwv, seen);
        check(name, {28'h0, seen}, {28'h0, er});
    endtask

    initial begin
        logic [3:0] seen;
        nRST = 1'b0; pending = '0; ena = '0; v = '0; osrdy = 1'b1;
        cen = 1'b0; cidx = '0; cw = '0;
        model_reset();

        // Reset, then arbitration latency and unit-weight rotation
        add(1, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'b0000);
        add(0, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'b0001);
        add(0, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0001);
        add(0, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0010);
        add(0, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0100);
        add(0, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b1000);
        add(0, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0001);
        // Weights {2,1,3,0}: input 3 is disabled
        add(1, 4'b0000, 4'b0000, 1, 1, 0, 2, 4'b0000);
        add(0, 4'b0000, 4'b0000, 1, 1, 1, 1, 4'b0000);
        add(0, 4'b0000, 4'b0000, 1, 1, 2, 3, 4'b0000);
        add(0, 4'b0000, 4'b0000, 1, 1, 3, 0, 4'b0000);
        add(0, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0000);
        add(0, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0001);
        add(0, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0001);
        add(0, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0010);
        add(0, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0100);
        add(0, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0100);
        add(0, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0100);
        add(0, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0001);
        add(0, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0001);
        add(0, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0010);
        add(0, 4'b1111, 4'b1111, 1, 0, 0, 0, 4'b0100);

        for (int n = 0; n < tbl.size(); n++) begin
            if (tbl[n].rst_first) do_reset();
            step(1'b1, tbl[n].pend, tbl[n].want, tbl[n].srdy, tbl[n].ce, tbl[n].ci,
                 tbl[n].cwv, seen);
            check($sformatf("tbl_rdy[%0d]", n), {28'h0, seen}, {28'h0, tbl[n].exp_rdy});
        end
        check("cfg_rdy", {31'h0, crdy}, 32'h1);

        // Sink stall mid-burst: the count holds, then the burst completes
        do_reset();
        expect_step("t4_cfg",   1, 4'b0000, 4'b0000, 1, 1, 1, 3, 4'b0000);
        expect_step("t4_idle",  1, 4'b0010, 4'b0000, 1, 0, 0, 0, 4'b0000);
        expect_step("t4_x1",    1, 4'b0110, 4'b0010, 1, 0, 0, 0, 4'b0010);
        for (int k = 0; k < 5; k++)
            expect_step("t4_stall", 1, 4'b0110, 4'b0010, 0, 0, 0, 0, 4'b0000);
        expect_step("t4_x2",    1, 4'b0110, 4'b0010, 1, 0, 0, 0, 4'b0010);
        expect_step("t4_x3",    1, 4'b0110, 4'b0010, 1, 0, 0, 0, 4'b0010);
        expect_step("t4_rot",   1, 4'b0110, 4'b0000, 1, 0, 0, 0, 4'b0100);

        // Early release on a dropped pending, then return to IDLE
        do_reset();
        expect_step("t5_cfg",   1, 4'b0000, 4'b0000, 1, 1, 0, 4, 4'b0000);
        expect_step("t5_idle",  1, 4'b1111, 4'b0000, 1, 0, 0, 0, 4'b0000);
        expect_step("t5_x1",    1, 4'b1111, 4'b0001, 1, 0, 0, 0, 4'b0001);
        expect_step("t5_x2",    1, 4'b1111, 4'b0001, 1, 0, 0, 0, 4'b0001);
        expect_step("t5_drop",  1, 4'b1110, 4'b0000, 1, 0, 0, 0, 4'b0001);
        expect_step("t5_next",  1, 4'b1110, 4'b0000, 1, 0, 0, 0, 4'b0010);
        expect_step("t5_none",  1, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0010);
        expect_step("t5_idle2", 1, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000);

        // Weight lowered mid-burst, then reset mid-burst restores weights
        do_reset();
        expect_step("t6_cfg",   1, 4'b0000, 4'b0000, 1, 1, 2, 4, 4'b0000);
        expect_step("t6_idle",  1, 4'b0100, 4'b0000, 1, 0, 0, 0, 4'b0000);
        expect_step("t6_x1",    1, 4'b0110, 4'b0100, 1, 0, 0, 0, 4'b0100);
        expect_step("t6_x2",    1, 4'b0110, 4'b0100, 1, 0, 0, 0, 4'b0100);
        expect_step("t6_lower", 1, 4'b0110, 4'b0000, 1, 1, 2, 1, 4'b0100);
        expect_step("t6_x3",    1, 4'b0110, 4'b0100, 1, 0, 0, 0, 4'b0100);
        expect_step("t6_rot",   1, 4'b0110, 4'b0000, 1, 0, 0, 0, 4'b0010);
        expect_step("t6_rst",   0, 4'b0110, 4'b0010, 1, 0, 0, 0, 4'b0010);
        expect_step("t6_idle2", 1, 4'b0110, 4'b0000, 1, 0, 0, 0, 4'b0000);
        expect_step("t6_w1a",   1, 4'b0110, 4'b0010, 1, 0, 0, 0, 4'b0010);
        expect_step("t6_w1b",   1, 4'b0110, 4'b0100, 1, 0, 0, 0, 4'b0100);
        expect_step("t6_w1c",   1, 4'b0110, 4'b0000, 1, 0, 0, 0, 4'b0010);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 800; n++) begin
            step(($urandom % 150) != 0, 4'($urandom), 4'($urandom), ($urandom % 4) != 0,
                 ($urandom % 8) == 0, 2'($urandom), 4'($urandom % 4), seen);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
